// File: rtl/rv_pipe_ctrl.sv
// Pipeline control unit: stage enables, bubble insertion and performance counters
// for a five-stage in-order pipeline with redirect refill and data-memory wait.
module rv_pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             i_pcu_clk,
    input  logic             i_pcu_rstn,
    input  logic             i_pcu_redirect_ex,
    input  logic             i_pcu_load_use_id,
    input  logic             i_pcu_imem_ready,
    input  logic             i_pcu_dmem_busy,
    output logic             o_pcu_pc_en,
    output logic             o_pcu_ifid_en,
    output logic             o_pcu_idex_en,
    output logic             o_pcu_exmem_en,
    output logic             o_pcu_ifid_flush,
    output logic             o_pcu_idex_flush,
    output logic [CNT_W-1:0] o_pcu_flush_cnt,
    output logic [CNT_W-1:0] o_pcu_stall_cnt,
    output logic [1:0]       o_pcu_state
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REFILL   = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           next_state;
    state_t           eff_state;
    logic             ret_refill;
    logic             next_ret_refill;
    logic             accept_redirect;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] stall_cnt;

    // While waiting on data memory the pipeline behaves as the state it left,
    // so the release cycle already carries that state's enables.
    assign eff_state = (state == MEM_WAIT) ? (ret_refill ? REFILL : RUN) : state;

    // NOTE: combinational block uses blocking assignments and gives every output
    // a default first, so no path can infer a latch.
    always_comb begin
        o_pcu_pc_en      = 1'b0;
        o_pcu_ifid_en    = 1'b0;
        o_pcu_idex_en    = 1'b0;
        o_pcu_exmem_en   = 1'b0;
        o_pcu_ifid_flush = 1'b0;
        o_pcu_idex_flush = 1'b0;
        next_state       = state;
        next_ret_refill  = ret_refill;
        accept_redirect  = 1'b0;

        if (!i_pcu_rstn) begin
            // Reset holds both pipeline registers as bubbles.
            o_pcu_ifid_flush = 1'b1;
            o_pcu_idex_flush = 1'b1;
        end else if (i_pcu_dmem_busy) begin
            // Freeze everything; EX is frozen so a concurrent redirect is re-seen later.
            next_state = MEM_WAIT;
            if (state != MEM_WAIT) begin
                next_ret_refill = (state == REFILL);
            end
        end else begin
            next_state = eff_state;
            case (eff_state)
                RUN: begin
                    o_pcu_idex_en  = 1'b1;
                    o_pcu_exmem_en = 1'b1;
                    if (i_pcu_redirect_ex) begin
                        o_pcu_pc_en      = 1'b1;
                        o_pcu_ifid_en    = 1'b1;
                        o_pcu_ifid_flush = 1'b1;
                        o_pcu_idex_flush = 1'b1;
                        accept_redirect  = 1'b1;
                        next_state       = REFILL;
                    end else if (i_pcu_load_use_id) begin
                        o_pcu_idex_flush = 1'b1;
                    end else if (!i_pcu_imem_ready) begin
                        o_pcu_ifid_en    = 1'b1;
                        o_pcu_ifid_flush = 1'b1;
                    end else begin
                        o_pcu_pc_en   = 1'b1;
                        o_pcu_ifid_en = 1'b1;
                    end
                end
                REFILL: begin
                    // Only bubbles are in ID/EX here, so hazards from them are ignored.
                    o_pcu_ifid_en  = 1'b1;
                    o_pcu_idex_en  = 1'b1;
                    o_pcu_exmem_en = 1'b1;
                    if (i_pcu_imem_ready) begin
                        o_pcu_pc_en = 1'b1;
                        next_state  = RUN;
                    end else begin
                        o_pcu_ifid_flush = 1'b1;
                    end
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments and an asynchronous
    // active-low reset so the FSM aborts immediately, without waiting for a clock.
    always_ff @(posedge i_pcu_clk or negedge i_pcu_rstn) begin
        if (!i_pcu_rstn) begin
            state      <= RUN;
            ret_refill <= 1'b0;
            flush_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            state      <= next_state;
            ret_refill <= next_ret_refill;
            if (accept_redirect && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
            if (!o_pcu_pc_en && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
        end
    end

    assign o_pcu_flush_cnt = flush_cnt;
    assign o_pcu_stall_cnt = stall_cnt;
    assign o_pcu_state     = state;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Scoreboard bench for rv_pipe_ctrl: a behavioural model predicts each cycle's
// control word, state and counters; a CNT_W=4 copy checks counter saturation.
module tb_rv_pipe_ctrl;

    logic clk;
    logic rstn;
    logic redirect_ex;
    logic load_use_id;
    logic imem_ready;
    logic dmem_busy;

    logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
    logic [31:0] flush_cnt, stall_cnt;
    logic [1:0]  state;

    logic        pc_en4, ifid_en4, idex_en4, exmem_en4, ifid_flush4, idex_flush4;
    logic [3:0]  flush_cnt4, stall_cnt4;
    logic [1:0]  state4;

    rv_pipe_ctrl dut (
        .i_pcu_clk        (clk),
        .i_pcu_rstn       (rstn),
        .i_pcu_redirect_ex(redirect_ex),
        .i_pcu_load_use_id(load_use_id),
        .i_pcu_imem_ready (imem_ready),
        .i_pcu_dmem_busy  (dmem_busy),
        .o_pcu_pc_en      (pc_en),
        .o_pcu_ifid_en    (ifid_en),
        .o_pcu_idex_en    (idex_en),
        .o_pcu_exmem_en   (exmem_en),
        .o_pcu_ifid_flush (ifid_flush),
        .o_pcu_idex_flush (idex_flush),
        .o_pcu_flush_cnt  (flush_cnt),
        .o_pcu_stall_cnt  (stall_cnt),
        .o_pcu_state      (state)
    );

    rv_pipe_ctrl #(.CNT_W(4)) dut4 (
        .i_pcu_clk        (clk),
        .i_pcu_rstn       (rstn),
        .i_pcu_redirect_ex(redirect_ex),
        .i_pcu_load_use_id(load_use_id),
        .i_pcu_imem_ready (imem_ready),
        .i_pcu_dmem_busy  (dmem_busy),
        .o_pcu_pc_en      (pc_en4),
        .o_pcu_ifid_en    (ifid_en4),
        .o_pcu_idex_en    (idex_en4),
        .o_pcu_exmem_en   (exmem_en4),
        .o_pcu_ifid_flush (ifid_flush4),
        .o_pcu_idex_flush (idex_flush4),
        .o_pcu_flush_cnt  (flush_cnt4),
        .o_pcu_stall_cnt  (stall_cnt4),
        .o_pcu_state      (state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Control word order: {pc, ifid, idex, exmem, ifid_flush, idex_flush}
    typedef struct {
        logic [5:0] ctl;
        int         st;
        int         fc;
        int         sc;
    } exp_t;

    exp_t sb[$];

    int m_state;  // 0 RUN, 1 REFILL, 2 MEM_WAIT
    int m_ret;    // 0 RUN, 1 REFILL
    int m_flush;
    int m_stall;

    function automatic logic [5:0] model_ctl(input logic r, input logic lu,
                                             input logic im, input logic db);
        int eff;
        if (db) return 6'b000000;
        eff = (m_state == 2) ? m_ret : m_state;
        if (eff == 0) begin
            if (r)       return 6'b111111;
            if (lu)      return 6'b001101;
            if (!im)     return 6'b011110;
            return 6'b111100;
        end
        return im ? 6'b111100 : 6'b011110;
    endfunction

    task automatic model_update(input logic r, input logic im, input logic db, input logic pc);
        int eff;
        eff = (m_state == 2) ? m_ret : m_state;
        if (db) begin
            if (m_state != 2) m_ret = (m_state == 1) ? 1 : 0;
            m_state = 2;
        end else if (eff == 0 && r) begin
            m_state = 1;
            m_flush++;
        end else if (eff == 1 && im) begin
            m_state = 0;
        end else begin
            m_state = eff;
        end
        if (!pc) m_stall++;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ret   = 0;
        m_flush = 0;
        m_stall = 0;
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb.pop_front();
        check("ctl",       {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}, e.ctl);
        check("state",     state, e.st);
        check("flush_cnt", flush_cnt, e.fc);
        check("stall_cnt", stall_cnt, e.sc);
        check("stall_cnt4", stall_cnt4, (e.sc > 15) ? 15 : e.sc);
    endtask

    // Called just after a rising edge; leaves just after the next one.
    task automatic step(input logic r, input logic lu, input logic im, input logic db);
        exp_t e;
        redirect_ex = r;
        load_use_id = lu;
        imem_ready  = im;
        dmem_busy   = db;
        e.ctl = model_ctl(r, lu, im, db);
        e.st  = m_state;
        e.fc  = m_flush;
        e.sc  = m_stall;
        sb.push_back(e);
        @(negedge clk);
        compare_out();
        model_update(r, im, db, e.ctl[5]);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctl"},   {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}, 6'b000011);
        check({tag, "_state"}, state, 0);
        check({tag, "_fcnt"},  flush_cnt, 0);
        check({tag, "_scnt"},  stall_cnt, 0);
    endtask

    // Asserts reset between clock edges and checks the outputs before the next edge.
    task automatic do_reset(input string tag);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_values(tag);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn        = 1'b0;
        redirect_ex = 1'b0;
        load_use_id = 1'b0;
        imem_ready  = 1'b1;
        dmem_busy   = 1'b0;
        model_reset();
        #1;
        check_reset_values("por");
        @(posedge clk);
        #1;
        check_reset_values("por_hold");
        rstn = 1'b1;

        // Redirect, two fetch misses in REFILL, then back to RUN.
        step(0, 0, 1, 0);
        do_reset("rst_a");
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("refill_done_state", state, 0);
        check("refill_done_fcnt", flush_cnt, 1);
        check("refill_done_scnt", stall_cnt, 2);
        step(0, 0, 1, 0);

        // Single load-use stall, then a RUN fetch miss.
        do_reset("rst_b");
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        check("load_use_scnt", stall_cnt, 1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);

        // Data-memory wait entered from REFILL, hazards ignored in REFILL.
        do_reset("rst_c");
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(1, 1, 0, 0);
        step(0, 0, 1, 0);
        check("memwait_state", state, 0);
        check("memwait_scnt", stall_cnt, 5);
        step(0, 0, 1, 0);

        // Redirect blocked by dmem_busy, accepted once busy releases.
        do_reset("rst_d");
        step(1, 0, 1, 1);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        check("redir_busy_fcnt", flush_cnt, 1);
        step(0, 0, 1, 0);

        // Saturation: twenty load-use stalls.
        do_reset("rst_e");
        for (int i = 0; i < 20; i++) step(0, 1, 1, 0);
        check("sat_scnt4", stall_cnt4, 15);
        check("sat_scnt", stall_cnt, 20);

        // Asynchronous reset in the middle of MEM_WAIT.
        do_reset("rst_f");
        step(1, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        check("pre_abort_state", state, 2);
        do_reset("abort");
        step(0, 0, 1, 0);

        // Random traffic against the model.
        do_reset("rst_g");
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_pipe_ctrl.md
RV_PIPE_CTRL -- requirements
Module: rv_pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have port i_pcu_clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 SHALL have port i_pcu_rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_pcu_redirect_ex  input  1  EX-stage redirect request (branch mispredict or jalr) from the branch unit.
REQ-005 SHALL have port i_pcu_load_use_id  input  1  load-use hazard detected in ID.
REQ-006 SHALL have port i_pcu_imem_ready  input  1  instruction memory returns a valid fetch this cycle.
REQ-007 SHALL have port i_pcu_dmem_busy  input  1  data memory busy; MEM stage cannot complete.
REQ-008 SHALL have ports o_pcu_pc_en, o_pcu_ifid_en, o_pcu_idex_en, o_pcu_exmem_en  output  1 each  stage register load enables.
REQ-009 SHALL have ports o_pcu_ifid_flush, o_pcu_idex_flush  output  1 each  bubble insert into IF/ID, ID/EX.
REQ-010 SHALL have port o_pcu_flush_cnt  output  CNT_W  count of accepted redirects.
REQ-011 SHALL have port o_pcu_stall_cnt  output  CNT_W  count of cycles with o_pcu_pc_en=0 while out of reset.
REQ-012 SHALL have port o_pcu_state  output  2  current FSM state: RUN=0, REFILL=1, MEM_WAIT=2.

Function
REQ-013 SHALL implement FSM states RUN, REFILL, MEM_WAIT plus a 1-bit saved return state (RUN or REFILL).
REQ-014 SHALL evaluate events with priority dmem_busy > redirect_ex > load_use_id > !imem_ready.
REQ-015 SHALL, any state, dmem_busy=1: all enables 0, both flushes 0; next state MEM_WAIT; on entry from RUN/REFILL save that state as return state.
REQ-016 SHALL, in MEM_WAIT with dmem_busy=0, produce outputs of the saved return state that cycle and return to it next cycle (no lost cycle).
REQ-017 SHALL, in RUN with redirect_ex=1 and dmem_busy=0: pc_en=1, ifid_flush=1, idex_flush=1, ifid_en=1, idex_en=1, exmem_en=1; next state REFILL; load_use_id ignored.
REQ-018 SHALL, in RUN with load_use_id=1 (no higher event): pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1.
REQ-019 SHALL, in RUN with imem_ready=0 (no higher event): pc_en=0, ifid_flush=1, ifid_en=1, idex_en=1, exmem_en=1.
REQ-020 SHALL, in RUN with no event: all enables 1, both flushes 0.
REQ-021 SHALL, in REFILL, ignore load_use_id and redirect_ex (ID/EX hold bubbles); imem_ready=0: pc_en=0, ifid_flush=1, others enabled; imem_ready=1: all enables 1, flushes 0, next state RUN.
REQ-022 SHALL increment o_pcu_flush_cnt by 1 per REQ-017 cycle; saturate at 2^CNT_W-1.
REQ-023 SHALL increment o_pcu_stall_cnt by 1 per cycle with pc_en=0 and rstn=1; saturate at 2^CNT_W-1.
REQ-024 SHALL drive enables/flushes combinationally from state and current inputs (same-cycle response, zero latency).
REQ-025 SHALL treat redirect and dmem_busy in same cycle as dmem_busy only; redirect is re-sampled after release since EX is frozen.

Reset
REQ-026 SHALL, while i_pcu_rstn=0: state RUN, return state RUN, both counters 0, all enables 0, both flushes 1.
REQ-027 SHALL, on deassertion, start in RUN with no pending redirect or stall; reset asserted mid-REFILL/MEM_WAIT aborts immediately to REQ-026 values.

Verification
REQ-028 SHALL cover: RUN, redirect_ex=1 one cycle, imem_ready=0 two cycles then 1 -> flushes both 1 cycle 0, state REFILL cycles 1-3, RUN cycle 4, flush_cnt=1, stall_cnt=2.
REQ-029 SHALL cover: load_use_id=1 one cycle in RUN -> pc_en=0, ifid_en=0, idex_flush=1 that cycle only; stall_cnt=1.
REQ-030 SHALL cover: REFILL entered, dmem_busy=1 three cycles -> all enables 0, state MEM_WAIT, then REFILL resumes; stall_cnt +3 plus REFILL stall cycles.
REQ-031 SHALL cover: redirect_ex=1 and dmem_busy=1 same cycle, busy released next cycle with redirect held -> redirect accepted cycle after release, flush_cnt=1 not 2.
REQ-032 SHALL cover: CNT_W=4, sixteen+ load-use stalls -> stall_cnt holds 15.
REQ-033 SHALL cover: rstn=0 asynchronously mid-MEM_WAIT -> state 0, counters 0, enables 0, flushes 1 before next clock edge.
